// File: rtl/ps2_kbd_rx_if.sv
// Key-event bus between the PS/2 keyboard receiver (master) and its consumer (slave).
// Carries the FWFT FIFO head, the pop request and the per-frame status pulses.
interface ps2_kbd_rx_if;
    logic       rd_en;
    logic       valid;
    logic [7:0] code;
    logic       is_ext;
    logic       is_break;
    logic       fifo_full;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    modport master (
        input  rd_en,
        output valid, code, is_ext, is_break, fifo_full,
        output parity_err, frame_err, overflow
    );

    modport slave (
        output rd_en,
        input  valid, code, is_ext, is_break, fifo_full,
        input  parity_err, frame_err, overflow
    );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise and filter the PS/2 lines, deframe 11-bit frames,
// fold E0/F0 prefixes into flags and queue key events in a first-word-fall-through FIFO.
module ps2_kbd_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PS2_CLK,
    input  logic              PS2_DAT,
    ps2_kbd_rx_if.master      evt
);

    localparam int FLT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FCNT_W  = PTR_W + 1;
    localparam int ENTRY_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // True when the vector holds an odd number of ones.
    function automatic logic odd_ones(input logic [8:0] v);
        return ^v;
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] dat_sync_r;
    logic                   clk_s;
    logic                   dat_s;

    logic                   filt_r;
    logic                   filt_d_r;
    logic [FLT_W-1:0]       flt_cnt_r;
    logic                   fall_r;

    rx_state_t              state_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             shift_r;
    logic                   par_r;
    logic                   ext_r;
    logic                   brk_r;
    logic [TO_W-1:0]        to_cnt_r;
    logic                   parity_err_r;
    logic                   frame_err_r;

    logic                   stop_eval_s;
    logic                   par_bad_s;
    logic                   stop_bad_s;
    logic                   push_s;
    logic                   timeout_s;
    logic [ENTRY_W-1:0]     push_data_s;

    logic [ENTRY_W-1:0]     mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [FCNT_W-1:0]      count_r;
    logic                   valid_r;
    logic                   full_r;
    logic                   overflow_r;
    logic [ENTRY_W-1:0]     head_r;

    logic                   pop_s;
    logic                   wr_ok_s;
    logic                   ovf_s;
    logic [PTR_W-1:0]       rd_ptr_nxt_s;
    logic [FCNT_W-1:0]      count_nxt_s;
    logic [ENTRY_W-1:0]     head_nxt_s;

    assign clk_s = clk_sync_r[SYNC_STAGES-1];
    assign dat_s = dat_sync_r[SYNC_STAGES-1];

    // Input synchronisers; preset high because an idle PS/2 bus floats high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync_r <= {SYNC_STAGES{1'b1}};
            dat_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], PS2_DAT};
        end
    end

    // Glitch filter: filtered clock only follows after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_r    <= 1'b1;
            flt_cnt_r <= {FLT_W{1'b0}};
        end else if (clk_s == filt_r) begin
            flt_cnt_r <= {FLT_W{1'b0}};
        end else if (flt_cnt_r == FLT_W'(FILTER_LEN - 1)) begin
            filt_r    <= ~filt_r;
            flt_cnt_r <= {FLT_W{1'b0}};
        end else begin
            flt_cnt_r <= flt_cnt_r + FLT_W'(1);
        end
    end

    // Falling-edge strobe, one cycle, the cycle after the filtered clock drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_d_r <= 1'b1;
            fall_r   <= 1'b0;
        end else begin
            filt_d_r <= filt_r;
            fall_r   <= filt_d_r & ~filt_r;
        end
    end

    // Frame evaluation on the stop-bit strobe and the inter-edge timeout condition.
    always_comb begin
        stop_eval_s = fall_r && (state_r == ST_STOP);
        par_bad_s   = (odd_ones({shift_r, par_r}) == 1'b0);
        stop_bad_s  = (dat_s == 1'b0);
        push_data_s = {ext_r, brk_r, shift_r};
        if (stop_eval_s && !par_bad_s && !stop_bad_s &&
            (shift_r != 8'hE0) && (shift_r != 8'hF0)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (!fall_r && (state_r != ST_IDLE) && (to_cnt_r == TO_W'(TIMEOUT_CYC - 1))) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Deframing FSM with prefix flags, timeout counter and error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            par_r        <= 1'b0;
            ext_r        <= 1'b0;
            brk_r        <= 1'b0;
            to_cnt_r     <= {TO_W{1'b0}};
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (fall_r || (state_r == ST_IDLE)) begin
                to_cnt_r <= {TO_W{1'b0}};
            end else begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end

            if (timeout_s) begin
                state_r     <= ST_IDLE;
                frame_err_r <= 1'b1;
                ext_r       <= 1'b0;
                brk_r       <= 1'b0;
            end else if (fall_r) begin
                case (state_r)
                    ST_IDLE: begin
                        if (!dat_s) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            state_r   <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        shift_r   <= {dat_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_PARITY: begin
                        par_r   <= dat_s;
                        state_r <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_r <= ST_IDLE;
                        // Parity is judged before the stop bit so only one pulse fires per frame.
                        if (par_bad_s) begin
                            parity_err_r <= 1'b1;
                            ext_r        <= 1'b0;
                            brk_r        <= 1'b0;
                        end else if (stop_bad_s) begin
                            frame_err_r  <= 1'b1;
                            ext_r        <= 1'b0;
                            brk_r        <= 1'b0;
                        end else if (shift_r == 8'hE0) begin
                            ext_r        <= 1'b1;
                        end else if (shift_r == 8'hF0) begin
                            brk_r        <= 1'b1;
                        end else begin
                            ext_r        <= 1'b0;
                            brk_r        <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // FIFO next-state: head output is precomputed so it can be registered with valid.
    always_comb begin
        pop_s        = evt.rd_en && valid_r;
        ovf_s        = push_s && (count_r == FCNT_W'(FIFO_DEPTH)) && !pop_s;
        wr_ok_s      = push_s && !ovf_s;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        count_nxt_s  = count_r + FCNT_W'(wr_ok_s) - FCNT_W'(pop_s);
        if (count_nxt_s == FCNT_W'(0)) begin
            head_nxt_s = {ENTRY_W{1'b0}};
        end else if (wr_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = push_data_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage, pointers and registered head/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {FCNT_W{1'b0}};
            valid_r    <= 1'b0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            head_r     <= {ENTRY_W{1'b0}};
        end else begin
            if (wr_ok_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            valid_r    <= (count_nxt_s != FCNT_W'(0));
            full_r     <= (count_nxt_s == FCNT_W'(FIFO_DEPTH));
            overflow_r <= ovf_s;
            head_r     <= head_nxt_s;
        end
    end

    assign evt.valid      = valid_r;
    assign evt.is_ext     = head_r[9];
    assign evt.is_break   = head_r[8];
    assign evt.code       = head_r[7:0];
    assign evt.fifo_full  = full_r;
    assign evt.parity_err = parity_err_r;
    assign evt.frame_err  = frame_err_r;
    assign evt.overflow   = overflow_r;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: bit-bangs PS/2 frames and checks decoded events
// against a scoreboard queue of {ext, brk, code} entries.
module tb_ps2_kbd_rx;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 200;
    localparam int FIFO_DEPTH  = 4;
    localparam int HALF        = 20;
    localparam int LATENCY     = SYNC_STAGES + FILTER_LEN + 2;

    logic clk;
    logic rst_n;
    logic ps2_clk;
    logic ps2_dat;

    ps2_kbd_rx_if bus ();

    ps2_kbd_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .PS2_CLK (ps2_clk),
        .PS2_DAT (ps2_dat),
        .evt     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [9:0] exp_q [$];
    int lat;

    // Pulse monitors: cycles high and rising edges of each status pulse.
    int perr_hi = 0, perr_ev = 0, ferr_hi = 0, ferr_ev = 0, ovf_hi = 0, ovf_ev = 0, both_cnt = 0;
    logic perr_p = 1'b0, ferr_p = 1'b0, ovf_p = 1'b0;
    always @(negedge clk) begin
        if (bus.parity_err) perr_hi++;
        if (bus.frame_err)  ferr_hi++;
        if (bus.overflow)   ovf_hi++;
        if (bus.parity_err && !perr_p) perr_ev++;
        if (bus.frame_err  && !ferr_p) ferr_ev++;
        if (bus.overflow   && !ovf_p)  ovf_ev++;
        if (bus.parity_err && bus.frame_err) both_cnt++;
        perr_p = bus.parity_err;
        ferr_p = bus.frame_err;
        ovf_p  = bus.overflow;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    // Drive nbits of a frame; records stop-edge-to-valid latency and can pop at a given cycle.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input int pop_at);
        logic [10:0] f;
        f   = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        lat = -1;
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            for (int j = 1; j <= HALF; j++) begin
                @(negedge clk);
                if (i == 10) begin
                    if (bus.valid && lat < 0) lat = j;
                    if (j == pop_at)     bus.rd_en = 1'b1;
                    if (j == pop_at + 1) bus.rd_en = 1'b0;
                end
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11, -1);
    endtask

    // Bounded wait for a head entry, then pop it.
    task automatic pop_one(output logic [9:0] head, output bit ok);
        ok   = 1'b0;
        head = 10'h000;
        for (int k = 0; k < 200; k++) begin
            if (bus.valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            head = {bus.is_ext, bus.is_break, bus.code};
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [14:0] outs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        outs = {bus.valid, bus.code, bus.is_ext, bus.is_break, bus.fifo_full,
                bus.parity_err, bus.frame_err, bus.overflow};
        vec_cnt++;
        if (outs !== 15'h0000) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %h want 0000", outs);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single;
        logic [9:0] h;
        logic [9:0] e;
        bit ok;
        exp_q.push_back({2'b00, 8'h1C});
        send_good(8'h1C);
        vec_cnt++;
        if (lat !== LATENCY) begin
            err_cnt++;
            $display("FAIL t1_latency: got %0d want %0d", lat, LATENCY);
        end
        pop_one(h, ok);
        e = exp_q.pop_front();
        vec_cnt++;
        if (!ok || h !== e) begin
            err_cnt++;
            $display("FAIL t1_head: got %h ok=%0d want %h", h, ok, e);
        end
        vec_cnt++;
        if (bus.valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL t1_empty_after_pop: valid %b want 0", bus.valid);
        end
    endtask

    task automatic test_prefix;
        logic [9:0] h;
        logic [9:0] e;
        bit ok;
        int p0, f0;
        p0 = perr_ev; f0 = ferr_ev;
        send_good(8'hF0);
        vec_cnt++;
        if (bus.valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL t2_no_prefix_event: valid %b want 0", bus.valid);
        end
        send_good(8'h1C);
        exp_q.push_back({2'b01, 8'h1C});
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        exp_q.push_back({2'b11, 8'h75});
        for (int n = 0; n < 2; n++) begin
            pop_one(h, ok);
            e = exp_q.pop_front();
            vec_cnt++;
            if (!ok || h !== e) begin
                err_cnt++;
                $display("FAIL t2_event%0d: got %h ok=%0d want %h", n, h, ok, e);
            end
        end
        vec_cnt++;
        if (bus.valid !== 1'b0 || perr_ev != p0 || ferr_ev != f0) begin
            err_cnt++;
            $display("FAIL t2_clean: valid %b perr+%0d ferr+%0d want 0/0/0",
                     bus.valid, perr_ev - p0, ferr_ev - f0);
        end
    endtask

    task automatic test_parity;
        logic [9:0] h;
        logic [9:0] e;
        bit ok;
        int pe, ph, fe;
        send_good(8'hE0);
        pe = perr_ev; ph = perr_hi; fe = ferr_ev;
        send_frame(8'h1C, 1'b1, 1'b0, 11, -1);
        vec_cnt++;
        if (perr_ev - pe != 1 || perr_hi - ph != 1 || ferr_ev != fe || bus.valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL t3_parity_pulse: events %0d cycles %0d ferr %0d valid %b want 1/1/0/0",
                     perr_ev - pe, perr_hi - ph, ferr_ev - fe, bus.valid);
        end
        exp_q.push_back({2'b00, 8'h1C});
        send_good(8'h1C);
        pop_one(h, ok);
        e = exp_q.pop_front();
        vec_cnt++;
        if (!ok || h !== e) begin
            err_cnt++;
            $display("FAIL t3_flag_cleared: got %h ok=%0d want %h", h, ok, e);
        end
    endtask

    task automatic test_timeout;
        logic [9:0] h;
        logic [9:0] e;
        bit ok;
        int fe, fh, pe;
        fe = ferr_ev; fh = ferr_hi; pe = perr_ev;
        send_frame(8'h5A, 1'b0, 1'b0, 6, -1);
        repeat (TIMEOUT_CYC + 50) @(negedge clk);
        vec_cnt++;
        if (ferr_ev - fe != 1 || ferr_hi - fh != 1 || perr_ev != pe || bus.valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL t4_timeout: ferr events %0d cycles %0d perr %0d valid %b want 1/1/0/0",
                     ferr_ev - fe, ferr_hi - fh, perr_ev - pe, bus.valid);
        end
        exp_q.push_back({2'b00, 8'h2A});
        send_good(8'h2A);
        pop_one(h, ok);
        e = exp_q.pop_front();
        vec_cnt++;
        if (!ok || h !== e) begin
            err_cnt++;
            $display("FAIL t4_recover: got %h ok=%0d want %h", h, ok, e);
        end
    endtask

    task automatic test_overflow;
        logic [9:0] h;
        logic [9:0] e;
        bit ok;
        int oe, oh;
        logic [7:0] codes [5];
        codes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int n = 0; n < 4; n++) begin
            exp_q.push_back({2'b00, codes[n]});
            send_good(codes[n]);
        end
        vec_cnt++;
        if (bus.fifo_full !== 1'b1) begin
            err_cnt++;
            $display("FAIL t5_full: fifo_full %b want 1", bus.fifo_full);
        end
        oe = ovf_ev; oh = ovf_hi;
        send_good(codes[4]);
        vec_cnt++;
        if (ovf_ev - oe != 1 || ovf_hi - oh != 1 || bus.fifo_full !== 1'b1) begin
            err_cnt++;
            $display("FAIL t5_overflow: events %0d cycles %0d full %b want 1/1/1",
                     ovf_ev - oe, ovf_hi - oh, bus.fifo_full);
        end
        for (int n = 0; n < 4; n++) begin
            pop_one(h, ok);
            e = exp_q.pop_front();
            vec_cnt++;
            if (!ok || h !== e) begin
                err_cnt++;
                $display("FAIL t5_pop%0d: got %h ok=%0d want %h", n, h, ok, e);
            end
        end
        vec_cnt++;
        if (bus.valid !== 1'b0 || bus.fifo_full !== 1'b0) begin
            err_cnt++;
            $display("FAIL t5_drained: valid %b full %b want 0/0", bus.valid, bus.fifo_full);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] h;
        logic [9:0] e;
        bit ok;
        int oe;
        for (int n = 0; n < 4; n++) begin
            exp_q.push_back({2'b00, 8'h61 + 8'(n)});
            send_good(8'h61 + 8'(n));
        end
        oe = ovf_ev;
        // Pop lands on the same edge as the push of 0x65 while full.
        void'(exp_q.pop_front());
        exp_q.push_back({2'b00, 8'h65});
        send_frame(8'h65, 1'b0, 1'b0, 11, LATENCY - 1);
        vec_cnt++;
        if (ovf_ev != oe || bus.fifo_full !== 1'b1) begin
            err_cnt++;
            $display("FAIL bb_push_pop_full: overflow +%0d full %b want 0/1", ovf_ev - oe, bus.fifo_full);
        end
        for (int n = 0; n < 4; n++) begin
            pop_one(h, ok);
            e = exp_q.pop_front();
            vec_cnt++;
            if (!ok || h !== e) begin
                err_cnt++;
                $display("FAIL bb_pop%0d: got %h ok=%0d want %h", n, h, ok, e);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] h;
        logic [9:0] e;
        logic [14:0] outs;
        bit ok;
        int pe, fe;
        send_good(8'h33);
        send_good(8'hE0);
        send_frame(8'h1C, 1'b0, 1'b0, 4, -1);
        rst_n = 1'b0;
        @(negedge clk);
        outs = {bus.valid, bus.code, bus.is_ext, bus.is_break, bus.fifo_full,
                bus.parity_err, bus.frame_err, bus.overflow};
        vec_cnt++;
        if (outs !== 15'h0000) begin
            err_cnt++;
            $display("FAIL t6_reset_outputs: got %h want 0000", outs);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        pe = perr_ev; fe = ferr_ev;
        // Short low glitch on PS2_CLK with data low: must not be taken as a start bit.
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
        ps2_dat = 1'b1;
        exp_q.push_back({2'b00, 8'h1C});
        send_good(8'h1C);
        pop_one(h, ok);
        e = exp_q.pop_front();
        vec_cnt++;
        if (!ok || h !== e) begin
            err_cnt++;
            $display("FAIL t6_after_reset: got %h ok=%0d want %h", h, ok, e);
        end
        vec_cnt++;
        if (perr_ev != pe || ferr_ev != fe || bus.valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL t6_glitch: perr+%0d ferr+%0d valid %b want 0/0/0",
                     perr_ev - pe, ferr_ev - fe, bus.valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ps2_clk   = 1'b1;
        ps2_dat   = 1'b1;
        bus.rd_en = 1'b0;
        @(negedge clk);
        test_reset;
        test_single;
        test_prefix;
        test_parity;
        test_timeout;
        test_overflow;
        test_back_to_back;
        test_reset_mid_frame;
        vec_cnt++;
        if (both_cnt != 0) begin
            err_cnt++;
            $display("FAIL exclusive_pulses: %0d cycles with parity_err and frame_err, want 0", both_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
